ysyx_ifu: RTL and testbench
===========================

# ysyx_ifu

Instruction fetch unit for the ysyx single-issue RISC-V core, sitting directly upstream of the execute stage. It owns the architectural PC and fetches one 32-bit instruction at a time over a valid/ready instruction-memory port. It presents the instruction and its PC to decode/execute with a valid/ready handshake. On each accepted instruction it takes the branch decision (`BrE` / `jump_addr`) back from execute to select the next PC.

## Interface
**Parameters**
- `RESET_PC`, default `32'h8000_0000`: PC loaded on reset.

**Ports**
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_ready` input 1: memory accepts request.
- `imem_addr` output 32: fetch address, equal to the current `pc`.
- `imem_rsp_valid` input 1: response data valid, for one cycle.
- `imem_rsp_data` input 32: fetched instruction word.
- `imem_rsp_err` input 1: bus error, qualified by `imem_rsp_valid`.
- `inst_valid` output 1: `inst`/`pc` valid toward execute.
- `inst_ready` input 1: execute consumes the instruction this cycle.
- `inst` output 32: held instruction.
- `pc` output 32: PC of `inst`, which is also the current fetch PC.
- `BrE` input 1: branch/jump taken, sampled only on the handshake cycle.
- `jump_addr` input 32: taken target, sampled only on the handshake cycle.
- `fetch_err` output 1: sticky error flag.
- `fetch_count` output 32: number of instructions handed to execute.

## Operation
**States:** REQ, WAIT, HOLD, ERR.

**REQ**
- `imem_req_valid`=1 and `imem_addr`=`pc`.
- Request fires when `imem_req_ready`=1; go to WAIT.
- Any `imem_rsp_valid` seen while in REQ is ignored.

**WAIT**
- `imem_req_valid`=0.
- On `imem_rsp_valid`=1 with `imem_rsp_err`=0: capture `imem_rsp_data` into `inst` and go to HOLD.
- On `imem_rsp_valid`=1 with `imem_rsp_err`=1: set `fetch_err` and go to ERR.
- No timeout: the unit stays in WAIT indefinitely.

**HOLD**
- `inst_valid`=1. `inst` and `pc` are stable until the handshake.
- Handshake: `inst_valid` && `inst_ready`. On the handshake:
  - next PC = `BrE` ? `jump_addr` : `pc` + 4, using 32-bit wrap-around (`32'hFFFF_FFFC` + 4 = 0).
  - `fetch_count` increments, wrapping at 2^32.
  - Go to REQ.
- If `BrE`=1 and `jump_addr[1:0]` != 0: `fetch_err` is set, `pc` still loads `jump_addr`, and the state goes to ERR.

**ERR**
- Terminal state: all valids are 0 and `pc`/`inst` are frozen.
- Only `rst` leaves ERR.

**Invariants**
- At most one request is outstanding.
- `imem_req_valid` and `inst_valid` are never high in the same cycle.
- `inst_ready` outside HOLD has no effect.
- `BrE` and `jump_addr` are ignored except on the handshake cycle.

## Timing
**Reset**
- With `rst`=1 at a clock edge, the following take effect after that edge: state=REQ, `pc`=`RESET_PC`, `inst`=0, `fetch_err`=0, `fetch_count`=0.
- Resulting outputs: `inst_valid`=0, `imem_req_valid`=1, `imem_addr`=`RESET_PC`.
- Reset overrides everything in any state, including mid-WAIT and ERR.
- Memory is reset with the same `rst`; a stale response arriving in REQ is ignored.

**Best-case cadence** (ready and single-cycle memory)
- Cycle N: REQ, request fires.
- Cycle N+1: WAIT, `rsp_valid` arrives.
- Cycle N+2: HOLD with `inst_valid`=1; handshake.
- Cycle N+3: REQ at the new PC.
- Throughput is one instruction per 3 cycles.

**Register boundaries**
- All outputs are registered or decoded from registered state.
- No combinational path from `imem_rsp_*` to `inst`/`inst_valid`.
- Only `imem_req_valid` and `inst_valid` depend on state; there are no input→output combinational paths.

## Test plan
- **Reset fetch:** `rst` high for 2 cycles, memory ready, 1-cycle response `32'h00000013`.
  - Required: `imem_addr`=`32'h80000000` in the first cycle after reset.
  - Required: `inst_valid`=1 two cycles later with `inst`=`32'h00000013` and `pc`=`32'h80000000`.
- **Sequential fetch with backpressure:** hold `inst_ready`=0 for 5 cycles in HOLD.
  - Required: `inst` and `pc` stay stable and no new request is issued.
  - Required: after the handshake, the next `imem_addr`=`32'h80000004` and `fetch_count`=1.
- **Taken branch:** handshake with `BrE`=1 and `jump_addr`=`32'h80000100`.
  - Required: the next request address is `32'h80000100`.
  - Also: with `BrE`=0 on the handshake, `jump_addr` is ignored.
- **Slow memory:** `imem_req_ready` low for 3 cycles, then response after 4 more cycles.
  - Required: address held throughout and a single request issued.
  - Required: a spurious `rsp_valid` injected during REQ is ignored.
- **Errors:**
  - `imem_rsp_err`=1 → ERR; `fetch_err`=1 and stays set; no `inst_valid`.
  - Separately, taken `jump_addr`=`32'h80000102` → `fetch_err`=1, `pc`=`32'h80000102`, fetch stalls.
  - Required: `rst` clears both cases back to the reset state.
- **Reset mid-operation and PC wrap:**
  - Assert `rst` in WAIT: required next state REQ at `RESET_PC`, and a late response is dropped.
  - Separately, from `pc`=`32'hFFFFFFFC`, a not-taken handshake → next `imem_addr`=`32'h00000000`.

Source files
------------

// File: rtl/ysyx_ifu_if.sv
// ysyx IFU bus bundle: instruction-memory request/response
// plus the instruction handoff and branch feedback with execute.
interface ysyx_ifu_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        BrE;
   logic [31:0] jump_addr;

   modport master (
      output imem_req_valid, imem_addr,
      input  imem_req_ready,
      input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
      output inst_valid, inst, pc,
      input  inst_ready, BrE, jump_addr
   );

   modport slave (
      input  imem_req_valid, imem_addr,
      output imem_req_ready,
      output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
      input  inst_valid, inst, pc,
      output inst_ready, BrE, jump_addr
   );
endinterface

// File: rtl/ysyx_ifu.sv
// ysyx instruction fetch unit: one outstanding imem fetch,
// instruction held toward execute until the handshake.
module ysyx_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic              clk,
   input  logic              rst,
   ysyx_ifu_if.master        bus,
   output logic              fetch_err,
   output logic [31:0]       fetch_count
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_ERR
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic        err_q, err_d;
   logic [31:0] cnt_q, cnt_d;
   logic        hs;
   logic        misalign;

   assign hs       = (state_q == S_HOLD) && bus.inst_ready;
   assign misalign = bus.BrE && (bus.jump_addr[1:0] != 2'b00);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_REQ: begin
            if (bus.imem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.imem_rsp_valid) begin
               if (bus.imem_rsp_err) begin
                  err_d   = 1'b1;
                  state_d = S_ERR;
               end else begin
                  inst_d  = bus.imem_rsp_data;
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (hs) begin
               cnt_d = cnt_q + 32'd1;
               pc_d  = bus.BrE ? bus.jump_addr : pc_q + 32'd4;
               // misaligned target still loads pc so the fault address is visible
               if (misalign) begin
                  err_d   = 1'b1;
                  state_d = S_ERR;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_ERR: begin
            state_d = S_ERR;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         inst_q  <= 32'd0;
         err_q   <= 1'b0;
         cnt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.imem_req_valid = (state_q == S_REQ);
   assign bus.imem_addr      = pc_q;
   assign bus.inst_valid     = (state_q == S_HOLD);
   assign bus.inst           = inst_q;
   assign bus.pc             = pc_q;
   assign fetch_err          = err_q;
   assign fetch_count        = cnt_q;

endmodule

// File: tb/tb_ysyx_ifu.sv
// Bench for ysyx_ifu: plays memory and execute, checks
// against a transaction-level PC/count/error model.
module tb_ysyx_ifu;
   localparam logic [31:0] RPC = 32'h8000_0000;

   logic        clk;
   logic        rst;
   logic        fetch_err;
   logic [31:0] fetch_count;

   ysyx_ifu_if bus ();

   ysyx_ifu #(.RESET_PC(RPC)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .fetch_err   (fetch_err),
      .fetch_count (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_chk;
   int          n_pass;
   logic [31:0] m_pc;
   logic [31:0] m_cnt;
   logic        m_err;
   logic [31:0] m_inst;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".pc"}, bus.pc, m_pc);
      chk({tag, ".addr"}, bus.imem_addr, m_pc);
      chk({tag, ".cnt"}, fetch_count, m_cnt);
      chk({tag, ".err"}, {31'd0, fetch_err}, {31'd0, m_err});
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) tick();
      rst    = 1'b0;
      m_pc   = RPC;
      m_cnt  = 0;
      m_err  = 1'b0;
      m_inst = 32'd0;
      chk("rst.req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
      chk("rst.inst_valid", {31'd0, bus.inst_valid}, 32'd0);
      chk("rst.inst", bus.inst, 32'd0);
      chk_model("rst");
   endtask

   // memory accepts the request after ready_dly cycles; optional stray response
   task automatic req_phase(input int ready_dly, input bit spurious);
      chk("req.valid", {31'd0, bus.imem_req_valid}, 32'd1);
      chk("req.addr", bus.imem_addr, m_pc);
      for (int i = 0; i < ready_dly; i++) begin
         bus.imem_rsp_valid = spurious && (i == 0);
         bus.imem_rsp_data  = 32'hBAD0_BAD0;
         bus.imem_rsp_err   = 1'b0;
         tick();
         bus.imem_rsp_valid = 1'b0;
         chk("req.hold_valid", {31'd0, bus.imem_req_valid}, 32'd1);
         chk("req.hold_addr", bus.imem_addr, m_pc);
         chk("req.no_inst", {31'd0, bus.inst_valid}, 32'd0);
      end
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      chk("wait.no_req", {31'd0, bus.imem_req_valid}, 32'd0);
   endtask

   task automatic rsp_phase(input int rsp_dly, input logic [31:0] data,
                            input bit err);
      for (int i = 0; i < rsp_dly; i++) begin
         bus.imem_req_ready = 1'b1;
         tick();
         bus.imem_req_ready = 1'b0;
         chk("wait.single_req", {31'd0, bus.imem_req_valid}, 32'd0);
         chk("wait.no_inst", {31'd0, bus.inst_valid}, 32'd0);
      end
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = data;
      bus.imem_rsp_err   = err;
      tick();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_err   = 1'b0;
      if (err) m_err = 1'b1;
      else m_inst = data;
      chk("rsp.inst_valid", {31'd0, bus.inst_valid}, {31'd0, !err});
   endtask

   task automatic consume(input int stall, input bit bre,
                          input logic [31:0] jaddr);
      chk("hold.inst", bus.inst, m_inst);
      chk("hold.pc", bus.pc, m_pc);
      for (int i = 0; i < stall; i++) begin
         bus.BrE       = 1'b1;
         bus.jump_addr = $urandom;
         tick();
         chk("stall.inst", bus.inst, m_inst);
         chk("stall.pc", bus.pc, m_pc);
         chk("stall.no_req", {31'd0, bus.imem_req_valid}, 32'd0);
         chk("stall.valid", {31'd0, bus.inst_valid}, 32'd1);
      end
      bus.inst_ready = 1'b1;
      bus.BrE        = bre;
      bus.jump_addr  = jaddr;
      tick();
      bus.inst_ready = 1'b0;
      bus.BrE        = 1'b0;
      bus.jump_addr  = 32'd0;
      m_cnt = m_cnt + 32'd1;
      m_pc  = bre ? jaddr : m_pc + 32'd4;
      if (bre && jaddr[1:0] != 2'b00) m_err = 1'b1;
      chk("hs.req_valid", {31'd0, bus.imem_req_valid}, {31'd0, !m_err});
      chk("hs.inst_valid", {31'd0, bus.inst_valid}, 32'd0);
      chk_model("hs");
   endtask

   task automatic err_hold(input string tag);
      for (int i = 0; i < 4; i++) begin
         bus.imem_req_ready = 1'b1;
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = $urandom;
         bus.inst_ready     = 1'b1;
         tick();
      end
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.inst_ready     = 1'b0;
      chk({tag, ".req"}, {31'd0, bus.imem_req_valid}, 32'd0);
      chk({tag, ".iv"}, {31'd0, bus.inst_valid}, 32'd0);
      chk({tag, ".inst"}, bus.inst, m_inst);
      chk_model(tag);
   endtask

   initial begin
      logic [31:0] ja;
      logic [31:0] d;
      n_chk  = 0;
      n_pass = 0;
      rst = 1'b1;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'd0;
      bus.imem_rsp_err   = 1'b0;
      bus.inst_ready     = 1'b0;
      bus.BrE            = 1'b0;
      bus.jump_addr      = 32'd0;

      do_reset(2);
      req_phase(0, 1'b0);
      rsp_phase(0, 32'h0000_0013, 1'b0);
      consume(5, 1'b0, 32'h1234_5678);
      chk("seq.addr", bus.imem_addr, 32'h8000_0004);
      chk("seq.cnt", fetch_count, 32'd1);

      req_phase(0, 1'b0);
      rsp_phase(0, 32'h0000_0093, 1'b0);
      consume(0, 1'b1, 32'h8000_0100);
      chk("br.addr", bus.imem_addr, 32'h8000_0100);

      req_phase(3, 1'b1);
      rsp_phase(4, 32'h0010_0113, 1'b0);
      consume(1, 1'b0, 32'h0000_0040);
      chk("nt.addr", bus.imem_addr, 32'h8000_0104);

      req_phase(1, 1'b0);
      rsp_phase(1, 32'hFFFF_FFFF, 1'b1);
      err_hold("rsperr");
      do_reset(1);

      req_phase(0, 1'b0);
      rsp_phase(0, 32'h0000_0013, 1'b0);
      consume(0, 1'b1, 32'h8000_0102);
      chk("mis.pc", bus.pc, 32'h8000_0102);
      err_hold("miserr");
      do_reset(1);

      req_phase(2, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_pc = RPC; m_cnt = 0; m_err = 1'b0; m_inst = 32'd0;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
      tick();
      bus.imem_rsp_valid = 1'b0;
      chk("late.req", {31'd0, bus.imem_req_valid}, 32'd1);
      chk("late.iv", {31'd0, bus.inst_valid}, 32'd0);
      chk("late.inst", bus.inst, 32'd0);
      chk_model("late");

      req_phase(0, 1'b0);
      rsp_phase(0, 32'h0000_0013, 1'b0);
      consume(0, 1'b1, 32'hFFFF_FFFC);
      req_phase(0, 1'b0);
      rsp_phase(0, 32'h0000_0013, 1'b0);
      consume(0, 1'b0, 32'hFFFF_FFFC);
      chk("wrap.addr", bus.imem_addr, 32'h0000_0000);

      for (int k = 0; k < 40; k++) begin
         ja      = $urandom;
         ja[1:0] = 2'b00;
         d       = $urandom;
         req_phase($urandom_range(0, 3), 1'($urandom_range(0, 1)));
         rsp_phase($urandom_range(0, 4), d, 1'b0);
         consume($urandom_range(0, 3), 1'($urandom_range(0, 1)), ja);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
